// File: rtl/num_pkg.sv
// rtl/num_pkg.sv - width, tree-shape and saturation-limit helpers for the rounding adder
package num_pkg;

  // Full-precision width of a sum of num_input operands of width_in bits.
  function automatic int sum_width(input int num_input, input int width_in);
    return width_in + $clog2(num_input);
  endfunction

  // Register levels in the adder tree; a single input still gets one register.
  function automatic int adder_levels(input int num_input);
    return (num_input > 1) ? $clog2(num_input) : 1;
  endfunction

  // Operands present at a tree level (level 0 is the input vector).
  function automatic int level_count(input int num_input, input int level);
    return (num_input + (1 << level) - 1) >> level;
  endfunction

  // Flat index of the first operand of a level when all levels are laid end to end.
  function automatic int level_offset(input int num_input, input int level);
    int off;
    off = 0;
    for (int k = 0; k < level; k++) begin
      off += level_count(num_input, k);
    end
    return off;
  endfunction

  // Largest output code for the given width and signedness.
  function automatic longint sat_max(input int width_out, input int is_signed);
    if (is_signed != 0) begin
      return (64'sd1 <<< (width_out - 1)) - 64'sd1;
    end
    return (64'sd1 <<< width_out) - 64'sd1;
  endfunction

  // Smallest output code; fractional signed data keeps the range symmetric.
  function automatic longint sat_min(input int width_out, input int is_signed, input int is_fraction);
    if (is_signed == 0) begin
      return 64'sd0;
    end
    if (is_fraction != 0) begin
      return -((64'sd1 <<< (width_out - 1)) - 64'sd1);
    end
    return -(64'sd1 <<< (width_out - 1));
  endfunction

endpackage

// File: rtl/unbiased_round_sat.sv
// rtl/unbiased_round_sat.sv - registered round-half-to-even and saturation stage
module unbiased_round_sat
  import num_pkg::*;
#(
  parameter int WIDTH_IN    = 10,
  parameter int WIDTH_OUT   = 8,
  parameter int IS_SIGNED   = 1,
  parameter int IS_FRACTION = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [WIDTH_IN-1:0]  din,
  output logic [WIDTH_OUT-1:0] dout
);

  // Bits dropped (positive) or added (negative) to reach the output width.
  localparam int D  = WIDTH_IN - WIDTH_OUT;
  // Working width: the wider side plus a guard bit and a sign bit for unsigned data.
  localparam int WG = ((WIDTH_IN > WIDTH_OUT) ? WIDTH_IN : WIDTH_OUT) + 2;

  localparam logic signed [WG-1:0] SAT_HI = WG'(sat_max(WIDTH_OUT, IS_SIGNED));
  localparam logic signed [WG-1:0] SAT_LO = WG'(sat_min(WIDTH_OUT, IS_SIGNED, IS_FRACTION));

  logic signed [WG-1:0]  s_ext;
  logic signed [WG-1:0]  rnd;
  logic [WIDTH_OUT-1:0]  sat;

  if (IS_SIGNED != 0) begin : g_sext
    assign s_ext = WG'($signed(din));
  end else begin : g_zext
    assign s_ext = WG'(din);
  end

  if (D > 0) begin : g_round
    localparam logic [D-1:0] HALF = D'(1) << (D - 1);
    logic signed [WG-1:0] q;
    logic [D-1:0]         r;
    logic                 inc;
    // Floor division by 2^D; zero-extended unsigned data makes >>> act as a logical shift.
    assign q   = s_ext >>> D;
    assign r   = din[D-1:0];
    // Round up above the half point, and on an exact tie only when that lands on an even code.
    assign inc = (r > HALF) || ((r == HALF) && q[0]);
    assign rnd = q + WG'(inc);
  end else if (IS_FRACTION != 0) begin : g_widen_frac
    assign rnd = s_ext <<< (-D);
  end else begin : g_widen_int
    assign rnd = s_ext;
  end

  // Clamp the rounded value into the representable output range.
  always_comb begin
    sat = rnd[WIDTH_OUT-1:0];
    if (rnd > SAT_HI) begin
      sat = SAT_HI[WIDTH_OUT-1:0];
    end else if (rnd < SAT_LO) begin
      sat = SAT_LO[WIDTH_OUT-1:0];
    end
  end

  // Output register, the final pipeline stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout <= '0;
    end else if (ena) begin
      dout <= sat;
    end
  end

endmodule

// File: rtl/multi_input_adder_unbiased_round.sv
// rtl/multi_input_adder_unbiased_round.sv - pipelined multi-input adder with unbiased requantisation
module multi_input_adder_unbiased_round
  import num_pkg::*;
#(
  parameter int NUM_INPUT   = 2,
  parameter int WIDTH_IN    = 8,
  parameter int WIDTH_OUT   = 8,
  parameter int IS_SIGNED   = 1,
  parameter int IS_FRACTION = 0
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                ena,
  input  logic [NUM_INPUT-1:0][WIDTH_IN-1:0]  din,
  output logic [WIDTH_OUT-1:0]                dout
);

  localparam int WT   = sum_width(NUM_INPUT, WIDTH_IN);
  localparam int LA   = adder_levels(NUM_INPUT);
  // Registered tree nodes across all levels; the last one holds the full sum.
  localparam int NREG = level_offset(NUM_INPUT, LA + 1) - NUM_INPUT;

  if (NUM_INPUT < 1 || WIDTH_IN < 1 || WIDTH_OUT < 1) begin : g_bad_param
    $error("multi_input_adder_unbiased_round: NUM_INPUT, WIDTH_IN and WIDTH_OUT must be positive");
  end

  logic [WT-1:0] ext  [NUM_INPUT];
  logic [WT-1:0] node [NREG];

  // Extend every input to the full sum width so the tree can never overflow.
  for (genvar i = 0; i < NUM_INPUT; i++) begin : g_ext
    if (IS_SIGNED != 0) begin : g_s
      assign ext[i] = WT'($signed(din[i]));
    end else begin : g_u
      assign ext[i] = WT'(din[i]);
    end
  end

  // Balanced pairwise tree: each node adds two operands of the previous level,
  // an unpaired last operand is carried forward through its own register.
  for (genvar l = 1; l <= LA; l++) begin : g_lvl
    localparam int CNT_PREV = level_count(NUM_INPUT, l - 1);
    for (genvar j = 0; j < level_count(NUM_INPUT, l); j++) begin : g_node
      localparam int DST = level_offset(NUM_INPUT, l) - NUM_INPUT + j;
      localparam int SRC = level_offset(NUM_INPUT, l - 1) - NUM_INPUT + 2 * j;
      logic [WT-1:0] a;
      logic [WT-1:0] b;

      if (l == 1) begin : g_from_in
        assign a = ext[2*j];
        if (2 * j + 1 < CNT_PREV) begin : g_pair
          assign b = ext[2*j+1];
        end else begin : g_odd
          assign b = '0;
        end
      end else begin : g_from_node
        assign a = node[SRC];
        if (2 * j + 1 < CNT_PREV) begin : g_pair
          assign b = node[SRC+1];
        end else begin : g_odd
          assign b = '0;
        end
      end

      // One pipeline register per tree node.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          node[DST] <= '0;
        end else if (ena) begin
          node[DST] <= a + b;
        end
      end
    end
  end

  unbiased_round_sat #(
    .WIDTH_IN    (WT),
    .WIDTH_OUT   (WIDTH_OUT),
    .IS_SIGNED   (IS_SIGNED),
    .IS_FRACTION (IS_FRACTION)
  ) u_round (
    .clk  (clk),
    .rst  (rst),
    .ena  (ena),
    .din  (node[NREG-1]),
    .dout (dout)
  );

endmodule

// File: tb/tb_multi_input_adder_unbiased_round.sv
// tb/tb_multi_input_adder_unbiased_round.sv - scoreboard bench across several adder configurations
module tb_multi_input_adder_unbiased_round;

  localparam int NCFG = 9;
  localparam int WI   = 8;
  localparam int NDIR = 10;

  localparam int C_N  [NCFG] = '{4, 4, 4, 4, 4, 2,  2,  5, 1};
  localparam int C_WO [NCFG] = '{8, 6, 6, 8, 6, 12, 12, 8, 6};
  localparam int C_S  [NCFG] = '{1, 1, 1, 0, 0, 1,  1,  1, 1};
  localparam int C_F  [NCFG] = '{0, 0, 1, 0, 0, 0,  1,  0, 1};

  // Directed rows: first operand, value of every other operand.
  localparam int DIR_V0 [NDIR] = '{2, 6, 3, -2, -6, 127, -128, 254, -3, 0};
  localparam int DIR_VR [NDIR] = '{0, 0, 0,  0,  0, 127, -128, 255,  1, 0};

  logic clk = 1'b0;
  logic rst;
  logic ena;
  int   drow;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  task automatic check(input int cfg, input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL cfg%0d %s: dout=%0d expected=%0d at %0t", cfg, nm, act, exp, $time);
    end
  endtask

  // Reference: exact sum, round half to even, widen, then clamp to the output range.
  function automatic longint model(input longint s, input int wt, input int wo,
                                   input int sgn, input int frac);
    int     d;
    longint q, r, half, hi, lo;
    d = wt - wo;
    if (d > 0) begin
      q    = s >>> d;
      r    = s - q * (64'sd1 <<< d);
      half = 64'sd1 <<< (d - 1);
      if (r > half || (r == half && q[0] == 1'b1)) q = q + 1;
    end else if (frac != 0) begin
      q = s * (64'sd1 <<< (-d));
    end else begin
      q = s;
    end
    hi = (sgn != 0) ? (64'sd1 <<< (wo - 1)) - 1 : (64'sd1 <<< wo) - 1;
    lo = (sgn == 0) ? 64'sd0 : ((frac != 0) ? -hi : -hi - 1);
    if (q > hi) q = hi;
    if (q < lo) q = lo;
    return q & ((64'sd1 <<< wo) - 1);
  endfunction

  function automatic logic [WI-1:0] pick(input int row, input int i, input int mode,
                                         input logic [WI-1:0] same);
    logic [WI-1:0] v;
    if (row >= 0) begin
      v = (i == 0) ? WI'(DIR_V0[row]) : WI'(DIR_VR[row]);
    end else begin
      case (mode)
        0: v = WI'($urandom);
        1: v = WI'(int'($urandom_range(0, 16)) - 8);
        2: begin
          case ($urandom_range(0, 3))
            0: v = 8'h00;
            1: v = 8'h7f;
            2: v = 8'h80;
            default: v = 8'hff;
          endcase
        end
        default: v = same;
      endcase
    end
    return v;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int N   = C_N[g];
    localparam int WO  = C_WO[g];
    localparam int SG  = C_S[g];
    localparam int FR  = C_F[g];
    localparam int WT  = WI + $clog2(N);
    localparam int LAT = ((N > 1) ? $clog2(N) : 1) + 1;

    logic [N-1:0][WI-1:0] din;
    logic [WO-1:0]        dout;
    longint               exp_q[$];
    longint               cur_exp = 0;

    multi_input_adder_unbiased_round #(
      .NUM_INPUT   (N),
      .WIDTH_IN    (WI),
      .WIDTH_OUT   (WO),
      .IS_SIGNED   (SG),
      .IS_FRACTION (FR)
    ) dut (
      .clk  (clk),
      .rst  (rst),
      .ena  (ena),
      .din  (din),
      .dout (dout)
    );

    initial begin : stim
      int            mode;
      logic [WI-1:0] same;
      longint        s;
      longint        v;
      din = '0;
      forever begin
        @(negedge clk);
        #2;
        mode = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0: same = 8'h00;
          1: same = 8'h7f;
          2: same = 8'h80;
          default: same = 8'hff;
        endcase
        for (int i = 0; i < N; i++) din[i] = pick(drow, i, mode, same);
        if (ena && !rst) begin
          s = 0;
          for (int i = 0; i < N; i++) begin
            v = longint'(din[i]);
            if (SG != 0 && din[i][WI-1]) v = v - (64'sd1 <<< WI);
            s = s + v;
          end
          exp_q.push_back(model(s, WT, WO, SG, FR));
        end
      end
    end

    initial begin : mon
      logic en_s;
      logic rst_s;
      forever begin
        @(posedge clk);
        en_s  = ena;
        rst_s = rst;
        #1;
        if (rst_s) begin
          cur_exp = 0;
        end else if (en_s) begin
          if (exp_q.size() >= LAT) cur_exp = exp_q.pop_front();
          else cur_exp = 0;
        end
        check(g, rst_s ? "reset" : (en_s ? "result" : "hold"), longint'(dout), cur_exp);
      end
    end

    always @(posedge rst) begin
      #1;
      exp_q.delete();
      cur_exp = 0;
      check(g, "rst_async", longint'(dout), 0);
    end
  end

  initial begin
    rst  = 1'b1;
    ena  = 1'b0;
    drow = -1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    ena = 1'b1;
    for (int k = 0; k < NDIR; k++) begin
      drow = k;
      @(negedge clk);
    end
    drow = -1;
    repeat (8) @(negedge clk);
    for (int c = 0; c < 240; c++) begin
      ena = ($urandom_range(0, 3) != 0);
      if (c == 120) begin
        @(posedge clk);
        #3 rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
      end
      @(negedge clk);
    end
    ena = 1'b1;
    repeat (12) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
